daq_fifo_wr_ctrl: RTL and testbench

- Downstream stage of the DAQ FIFO reset/initialisation FSM.
- Consumes that FSM's DONE (as INIT_DONE) and gates the DAQ event stream into the DAQ FIFO write port.
- Blocks all writes until FIFO initialisation completes.
- Writes or discards whole events based on FIFO occupancy, truncates oversized or overflowing events, and keeps drop/overflow statistics for slow control.

---
 rtl/daq_fifo_wr_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_daq_fifo_wr_ctrl.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/daq_fifo_wr_ctrl.sv
// rtl/daq_fifo_wr_ctrl.sv - DAQ event stream to FIFO write-port gate (optional TMR: DAQ_FIFO_WR_CTRL_TMR_EN)
module daq_fifo_wr_ctrl #(
    parameter int DW        = 16,
    parameter int MAX_WORDS = 1024,
    parameter int CW        = 16
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          INIT_DONE,
    input  logic          EVT_VLD,
    input  logic          EVT_SOP,
    input  logic          EVT_EOP,
    input  logic [DW-1:0] EVT_DATA,
    input  logic          FIFO_FULL,
    input  logic          FIFO_PFULL,
    output logic          FIFO_WREN,
    output logic [DW-1:0] FIFO_DIN,
    output logic          BUSY,
    output logic          OVFL,
    output logic          TRUNC,
    output logic [CW-1:0] DROP_CNT,
    output logic [CW-1:0] EVT_CNT
);

    localparam int WCW = $clog2(MAX_WORDS + 1);
`ifdef DAQ_FIFO_WR_CTRL_TMR_EN
    localparam int NCP = 3;
`else
    localparam int NCP = 1;
`endif

    // Three-bit encoding leaves spare codes; any of them falls back to S_WAIT_INIT.
    typedef enum logic [2:0] {
        S_WAIT_INIT = 3'd0,
        S_IDLE      = 3'd1,
        S_WRITE     = 3'd2,
        S_DISCARD   = 3'd3
    } state_t;

    logic [2:0]     r_state [NCP];
    logic [WCW-1:0] r_cnt   [NCP];
    logic           r_ovfl  [NCP];
    logic           r_trunc [NCP];
    logic [CW-1:0]  r_drop  [NCP];
    logic [CW-1:0]  r_evt   [NCP];
    logic           r_wren  [NCP];
    logic [DW-1:0]  r_din;
    logic           r_busy;

    logic [2:0]     w_state;
    logic [WCW-1:0] w_cnt;
    logic           w_ovfl;
    logic           w_trunc;
    logic [CW-1:0]  w_drop;
    logic [CW-1:0]  w_evt;
    logic           w_wren;

    logic [2:0]     w_nstate;
    logic [WCW-1:0] w_ncnt;
    logic           w_novfl;
    logic           w_ntrunc;
    logic [CW-1:0]  w_ndrop;
    logic [CW-1:0]  w_nevt;
    logic           w_nwren;
    logic           w_sop_rule;

`ifdef DAQ_FIFO_WR_CTRL_TMR_EN
    // Bitwise majority of the three copies; a single upset copy is outvoted.
    always_comb begin
        w_state = (r_state[0] & r_state[1]) | (r_state[0] & r_state[2]) | (r_state[1] & r_state[2]);
        w_cnt   = (r_cnt[0]   & r_cnt[1])   | (r_cnt[0]   & r_cnt[2])   | (r_cnt[1]   & r_cnt[2]);
        w_ovfl  = (r_ovfl[0]  & r_ovfl[1])  | (r_ovfl[0]  & r_ovfl[2])  | (r_ovfl[1]  & r_ovfl[2]);
        w_trunc = (r_trunc[0] & r_trunc[1]) | (r_trunc[0] & r_trunc[2]) | (r_trunc[1] & r_trunc[2]);
        w_drop  = (r_drop[0]  & r_drop[1])  | (r_drop[0]  & r_drop[2])  | (r_drop[1]  & r_drop[2]);
        w_evt   = (r_evt[0]   & r_evt[1])   | (r_evt[0]   & r_evt[2])   | (r_evt[1]   & r_evt[2]);
        w_wren  = (r_wren[0]  & r_wren[1])  | (r_wren[0]  & r_wren[2])  | (r_wren[1]  & r_wren[2]);
    end
`else
    // Single copy: the "voted" view is the register itself.
    always_comb begin
        w_state = r_state[0];
        w_cnt   = r_cnt[0];
        w_ovfl  = r_ovfl[0];
        w_trunc = r_trunc[0];
        w_drop  = r_drop[0];
        w_evt   = r_evt[0];
        w_wren  = r_wren[0];
    end
`endif

    // Next-state and write decision for the current input word, from voted state.
    always_comb begin
        w_nstate   = w_state;
        w_ncnt     = w_cnt;
        w_novfl    = w_ovfl;
        w_ntrunc   = w_trunc;
        w_ndrop    = w_drop;
        w_nevt     = w_evt;
        w_nwren    = 1'b0;
        w_sop_rule = 1'b0;
        case (w_state)
            S_WAIT_INIT: begin
                if (INIT_DONE) w_nstate = S_IDLE;
            end
            S_IDLE, S_WRITE, S_DISCARD: begin
                if (!INIT_DONE) begin
                    w_nstate = S_WAIT_INIT;
                end else if (EVT_VLD) begin
                    if (w_state == S_IDLE) begin
                        w_sop_rule = EVT_SOP;
                    end else if (w_state == S_WRITE) begin
                        if (FIFO_FULL) begin
                            w_novfl  = 1'b1;
                            w_nstate = EVT_EOP ? S_IDLE : S_DISCARD;
                        end else if ((w_cnt == WCW'(MAX_WORDS)) && !EVT_EOP) begin
                            w_ntrunc = 1'b1;
                            w_nstate = S_DISCARD;
                        end else if (EVT_SOP) begin
                            w_sop_rule = 1'b1;
                        end else begin
                            w_nwren = 1'b1;
                            if (w_cnt != WCW'(MAX_WORDS)) w_ncnt = w_cnt + WCW'(1);
                            if (EVT_EOP) w_nstate = S_IDLE;
                        end
                    end else begin
                        if (EVT_SOP)      w_sop_rule = 1'b1;
                        else if (EVT_EOP) w_nstate   = S_IDLE;
                    end
                    // A start-of-packet is judged on FIFO headroom alone, whatever state we came from.
                    if (w_sop_rule) begin
                        if (FIFO_FULL || FIFO_PFULL) begin
                            w_ndrop  = (&w_drop) ? w_drop : w_drop + CW'(1);
                            w_nstate = EVT_EOP ? S_IDLE : S_DISCARD;
                        end else begin
                            w_nwren  = 1'b1;
                            w_nevt   = (&w_evt) ? w_evt : w_evt + CW'(1);
                            w_ncnt   = WCW'(1);
                            w_nstate = EVT_EOP ? S_IDLE : S_WRITE;
                        end
                    end
                end
            end
            default: w_nstate = S_WAIT_INIT;
        endcase
    end

    // Every copy loads the same voted-next value, so an upset copy is rewritten on the next edge.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NCP; i++) begin
                r_state[i] <= S_WAIT_INIT;
                r_cnt[i]   <= '0;
                r_ovfl[i]  <= 1'b0;
                r_trunc[i] <= 1'b0;
                r_drop[i]  <= '0;
                r_evt[i]   <= '0;
                r_wren[i]  <= 1'b0;
            end
            r_din  <= '0;
            r_busy <= 1'b0;
        end else begin
            for (int i = 0; i < NCP; i++) begin
                r_state[i] <= w_nstate;
                r_cnt[i]   <= w_ncnt;
                r_ovfl[i]  <= w_novfl;
                r_trunc[i] <= w_ntrunc;
                r_drop[i]  <= w_ndrop;
                r_evt[i]   <= w_nevt;
                r_wren[i]  <= w_nwren;
            end
            if (w_nwren) r_din <= EVT_DATA;
            r_busy <= (w_nstate == S_WRITE) || (w_nstate == S_DISCARD);
        end
    end

    assign FIFO_WREN = w_wren;
    assign FIFO_DIN  = r_din;
    assign BUSY      = r_busy;
    assign OVFL      = w_ovfl;
    assign TRUNC     = w_trunc;
    assign DROP_CNT  = w_drop;
    assign EVT_CNT   = w_evt;

endmodule

// File: tb/tb_daq_fifo_wr_ctrl.sv
// tb/tb_daq_fifo_wr_ctrl.sv - table-driven bench for daq_fifo_wr_ctrl (MAX_WORDS=4)
module tb_daq_fifo_wr_ctrl;

    logic        CLK = 1'b0;
    logic        RST, INIT_DONE, EVT_VLD, EVT_SOP, EVT_EOP, FIFO_FULL, FIFO_PFULL;
    logic [15:0] EVT_DATA;
    logic        FIFO_WREN, BUSY, OVFL, TRUNC;
    logic [15:0] FIFO_DIN, DROP_CNT, EVT_CNT;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    daq_fifo_wr_ctrl #(.DW(16), .MAX_WORDS(4), .CW(16)) dut (
        .CLK(CLK), .RST(RST), .INIT_DONE(INIT_DONE),
        .EVT_VLD(EVT_VLD), .EVT_SOP(EVT_SOP), .EVT_EOP(EVT_EOP), .EVT_DATA(EVT_DATA),
        .FIFO_FULL(FIFO_FULL), .FIFO_PFULL(FIFO_PFULL),
        .FIFO_WREN(FIFO_WREN), .FIFO_DIN(FIFO_DIN), .BUSY(BUSY),
        .OVFL(OVFL), .TRUNC(TRUNC), .DROP_CNT(DROP_CNT), .EVT_CNT(EVT_CNT)
    );

    typedef struct {
        logic        init, vld, sop, eop, full, pfull;
        logic [15:0] d;
        logic        w, b, ov, tr;
        int          drop, evt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic init, vld, sop, eop, full, pfull, input logic [15:0] d,
                                input logic w, b, ov, tr, input int drop, evt);
        vec_t v;
        v.init = init; v.vld = vld; v.sop = sop; v.eop = eop; v.full = full; v.pfull = pfull;
        v.d = d; v.w = w; v.b = b; v.ov = ov; v.tr = tr; v.drop = drop; v.evt = evt;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic init, vld, sop, eop, full, pfull, input logic [15:0] d);
        @(negedge CLK);
        INIT_DONE = init; EVT_VLD = vld; EVT_SOP = sop; EVT_EOP = eop;
        FIFO_FULL = full; FIFO_PFULL = pfull; EVT_DATA = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        drive(v.init, v.vld, v.sop, v.eop, v.full, v.pfull, v.d);
        chk("wren", idx, 32'(FIFO_WREN), 32'(v.w));
        if (v.w) chk("din", idx, 32'(FIFO_DIN), 32'(v.d));
        chk("busy", idx, 32'(BUSY), 32'(v.b));
        chk("ovfl", idx, 32'(OVFL), 32'(v.ov));
        chk("trunc", idx, 32'(TRUNC), 32'(v.tr));
        chk("drop_cnt", idx, 32'(DROP_CNT), 32'(v.drop));
        chk("evt_cnt", idx, 32'(EVT_CNT), 32'(v.evt));
    endtask

    task automatic check_reset(input int idx);
        chk("rst_wren", idx, 32'(FIFO_WREN), 0);
        chk("rst_din", idx, 32'(FIFO_DIN), 0);
        chk("rst_busy", idx, 32'(BUSY), 0);
        chk("rst_ovfl", idx, 32'(OVFL), 0);
        chk("rst_trunc", idx, 32'(TRUNC), 0);
        chk("rst_drop", idx, 32'(DROP_CNT), 0);
        chk("rst_evt", idx, 32'(EVT_CNT), 0);
    endtask

    initial begin
        RST = 1'b1; INIT_DONE = 1'b0; EVT_VLD = 1'b0; EVT_SOP = 1'b0; EVT_EOP = 1'b0;
        FIFO_FULL = 1'b0; FIFO_PFULL = 1'b0; EVT_DATA = '0;

        //          init vld sop eop full pf  data      w  b  ov tr drop evt
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0000,  0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 16'h1111,  1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h2222,  1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 16'h0000,  0, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h3333,  1, 1, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 16'h4444,  1, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'hF000,  0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 16'hA001,  0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 1, 16'hA002,  0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'hA003,  0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'hA004,  0, 1, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 16'hA005,  0, 0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 16'hB001,  1, 1, 0, 0, 1, 2));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 16'hB002,  1, 0, 0, 0, 1, 2));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 16'hC001,  1, 1, 0, 0, 1, 3));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'hC002,  1, 1, 0, 0, 1, 3));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'hC003,  1, 1, 0, 0, 1, 3));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'hC004,  1, 1, 0, 0, 1, 3));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'hC005,  0, 1, 0, 1, 1, 3));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'hC006,  0, 1, 0, 1, 1, 3));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 16'hC007,  0, 0, 0, 1, 1, 3));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 16'hD001,  1, 1, 0, 1, 1, 4));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 16'hD002,  1, 0, 0, 1, 1, 4));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 16'hE001,  1, 1, 0, 1, 1, 5));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'hE002,  1, 1, 0, 1, 1, 5));
        tbl.push_back(mk(1, 1, 0, 0, 1, 0, 16'hE003,  0, 1, 1, 1, 1, 5));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'hE004,  0, 1, 1, 1, 1, 5));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'hE005,  0, 1, 1, 1, 1, 5));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 16'hE006,  0, 0, 1, 1, 1, 5));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 16'h6001,  1, 1, 1, 1, 1, 6));
        tbl.push_back(mk(1, 1, 0, 0, 0, 0, 16'h6002,  1, 1, 1, 1, 1, 6));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 16'h6003,  1, 1, 1, 1, 1, 7));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 16'h6004,  1, 0, 1, 1, 1, 7));
        tbl.push_back(mk(1, 1, 1, 0, 0, 1, 16'h7001,  0, 1, 1, 1, 2, 7));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 16'h7002,  1, 1, 1, 1, 2, 8));
        tbl.push_back(mk(1, 1, 0, 1, 0, 0, 16'h7003,  1, 0, 1, 1, 2, 8));
        tbl.push_back(mk(1, 1, 1, 1, 0, 0, 16'h8001,  1, 0, 1, 1, 2, 9));
        tbl.push_back(mk(1, 1, 1, 1, 0, 1, 16'h8002,  0, 0, 1, 1, 3, 9));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 16'h9001,  1, 1, 1, 1, 3, 10));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 16'h9002,  0, 0, 1, 1, 3, 10));
        tbl.push_back(mk(0, 1, 0, 0, 0, 0, 16'h9003,  0, 0, 1, 1, 3, 10));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 16'h9004,  0, 0, 1, 1, 3, 10));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 16'h9005,  0, 0, 1, 1, 3, 10));
        tbl.push_back(mk(1, 1, 1, 1, 0, 0, 16'h9100,  0, 0, 1, 1, 3, 10));
        tbl.push_back(mk(1, 1, 1, 1, 0, 0, 16'h9101,  1, 0, 1, 1, 3, 11));

        repeat (2) @(posedge CLK);
        #1;
        check_reset(0);
        @(negedge CLK);
        RST = 1'b0;

        // FIFO not yet initialised: 3-word events must never reach the write port.
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, (i % 3) == 0, (i % 3) == 2, 1'b0, 1'b0, 16'(16'h5000 + i));
            chk("init_wren", i, 32'(FIFO_WREN), 0);
            chk("init_busy", i, 32'(BUSY), 0);
        end

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

`ifdef DAQ_FIFO_WR_CTRL_TMR_EN
        apply(mk(1, 1, 1, 0, 0, 0, 16'hB0B1, 1, 1, 1, 1, 3, 12), 100);
        @(negedge CLK);
        dut.r_state[1] = 3'b111;
        apply(mk(1, 1, 0, 0, 0, 0, 16'hB0B2, 1, 1, 1, 1, 3, 12), 101);
        chk("tmr_copy", 101, 32'(dut.r_state[1]), 32'(dut.r_state[0]));
        apply(mk(1, 1, 0, 1, 0, 0, 16'hB0B3, 1, 0, 1, 1, 3, 12), 102);
`endif

        // Sticky flags and counters clear only on reset.
        @(negedge CLK);
        RST = 1'b1; EVT_VLD = 1'b0;
        @(posedge CLK);
        #1;
        check_reset(200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
